// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the registered ALU control sequencer:
//   - ALU operation codes (ADD..REMU), 4 bits wide, zero-extended by the user
//   - ALU_Op class constants driven by the main control unit
//   - funct7 encodings recognised by the decoder
//   - latency class type and a helper mapping an op code to its class
//   - sequencer state type
// Optional feature macro ALU_CTRL_RV32M_EN is consumed by the decoder and the
// sequencer, not by this package.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  // MULH, MULHSU and MULHU share this code; the datapath reads funct3 for signedness.
  localparam logic [3:0] OP_MULH = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REM  = 4'd14;
  localparam logic [3:0] OP_REMU = 4'd15;

  localparam logic [2:0] R_TYPE = 3'b000;
  localparam logic [2:0] I_TYPE = 3'b001;
  localparam logic [2:0] MEM    = 3'b010;
  localparam logic [2:0] BRANCH = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    LAT_SINGLE = 2'd0,
    LAT_MUL    = 2'd1,
    LAT_DIV    = 2'd2
  } lat_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  function automatic lat_class_e op_lat_class(input logic [3:0] op);
    lat_class_e lc;
    lc = LAT_SINGLE;
    case (op)
      OP_MUL, OP_MULH:                   lc = LAT_MUL;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:  lc = LAT_DIV;
      default:                           lc = LAT_SINGLE;
    endcase
    return lc;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational decode of {funct7, ALU_Op, funct3} into an ALU op code,
// an illegal-encoding flag and the latency class of the op.
// Optional feature: ALU_CTRL_RV32M_EN enables RV32M decoding of funct7=0000001
// in R-type; without it that encoding is illegal.
// Ports:
//   funct7_i   in  7  instruction[31:25]
//   funct3_i   in  3  instruction[14:12]
//   alu_op_i   in  3  class from the main control unit
//   op_o       out 4  decoded op code (ADD when illegal)
//   illegal_o  out 1  encoding is undefined
//   lat_o      out    latency class of op_o
// -----------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  input  logic [2:0] alu_op_i,
  output logic [3:0] op_o,
  output logic       illegal_o,
  output lat_class_e lat_o
);

  always_comb begin
    op_o      = OP_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      R_TYPE: begin
        case (funct7_i)
          F7_BASE: begin
            case (funct3_i)
              3'b000: op_o = OP_ADD;
              3'b001: op_o = OP_SLL;
              3'b010: op_o = OP_SLT;
              3'b011: op_o = OP_SLTU;
              3'b100: op_o = OP_XOR;
              3'b101: op_o = OP_SRL;
              3'b110: op_o = OP_OR;
              3'b111: op_o = OP_AND;
            endcase
          end
          F7_ALT: begin
            if (funct3_i == 3'b000)      op_o = OP_SUB;
            else if (funct3_i == 3'b101) op_o = OP_SRA;
            else                         illegal_o = 1'b1;
          end
`ifdef ALU_CTRL_RV32M_EN
          F7_MULDIV: begin
            case (funct3_i)
              3'b000:                 op_o = OP_MUL;
              3'b001, 3'b010, 3'b011: op_o = OP_MULH;
              3'b100:                 op_o = OP_DIV;
              3'b101:                 op_o = OP_DIVU;
              3'b110:                 op_o = OP_REM;
              3'b111:                 op_o = OP_REMU;
            endcase
          end
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      I_TYPE: begin
        // funct7 is immediate bits here; only the shift forms constrain it.
        case (funct3_i)
          3'b000: op_o = OP_ADD;
          3'b010: op_o = OP_SLT;
          3'b011: op_o = OP_SLTU;
          3'b100: op_o = OP_XOR;
          3'b110: op_o = OP_OR;
          3'b111: op_o = OP_AND;
          3'b001: begin
            if (funct7_i == F7_BASE) op_o = OP_SLL;
            else                     illegal_o = 1'b1;
          end
          3'b101: begin
            if (funct7_i == F7_BASE)     op_o = OP_SRL;
            else if (funct7_i == F7_ALT) op_o = OP_SRA;
            else                         illegal_o = 1'b1;
          end
        endcase
      end
      MEM:     op_o = OP_ADD;
      BRANCH:  op_o = OP_SUB;
      default: op_o = OP_ADD;
    endcase
    if (illegal_o) op_o = OP_ADD;
    lat_o = op_lat_class(op_o);
  end

endmodule

// File: rtl/alu_control_seq.sv
// -----------------------------------------------------------------------------
// alu_control_seq
// Registered ALU control for the EX stage. Decodes each accepted instruction,
// registers the op code, and (with RV32M) holds the op for MUL_LAT/DIV_LAT
// cycles while busy_o stalls the front end.
// Optional feature macro: ALU_CTRL_RV32M_EN. Undefined: no counter or BUSY
// state, busy_o tied 0, MUL_LAT/DIV_LAT unused.
// Ports:
//   clk              in   1     clock, rising edge
//   reset            in   1     asynchronous active-high reset
//   flush_i          in   1     synchronous pipeline flush (beats everything but reset)
//   stall_i          in   1     downstream hold
//   valid_i          in   1     instruction presented
//   funct7_i         in   7     instruction[31:25]
//   funct3_i         in   3     instruction[14:12]
//   ALU_Op_i         in   3     class from main control
//   ALU_Operation_o  out  OP_W  registered op code
//   valid_o          out  1     op code valid for the ALU
//   busy_o           out  1     multi-cycle op in progress, no accept
//   illegal_o        out  1     encoding undefined (qualified by valid_o)
// -----------------------------------------------------------------------------
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            valid_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      ALU_Op_i,
  output logic [OP_W-1:0] ALU_Operation_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            illegal_o
);

  logic [3:0]      dec_op;
  logic            dec_ill;
  lat_class_e      dec_lat;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            ill_q, ill_d;
  logic            busy;
  logic            accept;

  alu_ctrl_decode u_decode (
    .funct7_i  (funct7_i),
    .funct3_i  (funct3_i),
    .alu_op_i  (ALU_Op_i),
    .op_o      (dec_op),
    .illegal_o (dec_ill),
    .lat_o     (dec_lat)
  );

`ifdef ALU_CTRL_RV32M_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, load_cnt;
  logic             multi;

  assign busy = (state_q == ST_BUSY);

  // A latency of 1 behaves as a single-cycle op, so it never enters BUSY.
  always_comb begin
    multi    = 1'b0;
    load_cnt = '0;
    if (dec_lat == LAT_MUL && MUL_LAT > 1) begin
      multi    = 1'b1;
      load_cnt = CNT_W'(MUL_LAT - 1);
    end else if (dec_lat == LAT_DIV && DIV_LAT > 1) begin
      multi    = 1'b1;
      load_cnt = CNT_W'(DIV_LAT - 1);
    end
  end
`else
  logic unused_cfg;

  assign busy       = 1'b0;
  assign unused_cfg = (dec_lat != LAT_SINGLE) ^ (MUL_LAT > 0) ^ (DIV_LAT > 0);
`endif

  assign accept = valid_i && !busy && !stall_i && !flush_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q;
`ifdef ALU_CTRL_RV32M_EN
    cnt_d   = cnt_q;
`endif
    if (flush_i) begin
      state_d = ST_IDLE;
      op_d    = '0;
      ill_d   = 1'b0;
`ifdef ALU_CTRL_RV32M_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_OUT: begin
          if (accept) begin
            op_d    = OP_W'(dec_op);
            ill_d   = dec_ill;
            state_d = ST_OUT;
`ifdef ALU_CTRL_RV32M_EN
            if (multi) begin
              state_d = ST_BUSY;
              cnt_d   = load_cnt;
            end
`endif
          end else if (!(state_q == ST_OUT && stall_i)) begin
            // A stalled OUT keeps its outputs; otherwise the slot empties.
            state_d = ST_IDLE;
          end
        end
`ifdef ALU_CTRL_RV32M_EN
        ST_BUSY: begin
          // Counter ignores stall_i: the functional unit keeps working.
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_RV32M_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_RV32M_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ALU_Operation_o = op_q;
  assign valid_o         = (state_q == ST_OUT);
  assign busy_o          = busy;
  assign illegal_o       = ill_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_control_seq
// Directed self-checking bench for alu_control_seq (OP_W=4, MUL_LAT=3,
// DIV_LAT=8). Observed outputs are packed as {op[3:0], valid, busy, illegal}.
// Multi-cycle scenarios are built only when ALU_CTRL_RV32M_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_control_seq;

  logic       clk;
  logic       reset;
  logic       flush_i;
  logic       stall_i;
  logic       valid_i;
  logic [6:0] funct7_i;
  logic [2:0] funct3_i;
  logic [2:0] ALU_Op_i;
  logic [3:0] ALU_Operation_o;
  logic       valid_o;
  logic       busy_o;
  logic       illegal_o;

  logic [6:0] obs;
  int checks = 0;
  int errors = 0;

  assign obs = {ALU_Operation_o, valid_o, busy_o, illegal_o};

  alu_control_seq #(
    .OP_W    (4),
    .MUL_LAT (3),
    .DIV_LAT (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .stall_i         (stall_i),
    .valid_i         (valid_i),
    .funct7_i        (funct7_i),
    .funct3_i        (funct3_i),
    .ALU_Op_i        (ALU_Op_i),
    .ALU_Operation_o (ALU_Operation_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .illegal_o       (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry layout: {ALU_Op[2:0], funct7[6:0], funct3[2:0], exp_op[3:0], exp_ill}
  localparam int NV = 23;
  localparam logic [17:0] TBL [NV] = '{
    {3'b000, 7'b0000000, 3'b111, 4'd2, 1'b0},  // AND
    {3'b000, 7'b0000000, 3'b110, 4'd3, 1'b0},  // OR
    {3'b000, 7'b0100000, 3'b101, 4'd7, 1'b0},  // SRA
    {3'b000, 7'b0000000, 3'b101, 4'd6, 1'b0},  // SRL
    {3'b000, 7'b0000000, 3'b001, 4'd5, 1'b0},  // SLL
    {3'b000, 7'b0000000, 3'b011, 4'd9, 1'b0},  // SLTU
    {3'b000, 7'b0000000, 3'b010, 4'd8, 1'b0},  // SLT
    {3'b001, 7'b0000000, 3'b010, 4'd8, 1'b0},  // SLTI
    {3'b001, 7'b0100000, 3'b101, 4'd7, 1'b0},  // SRAI
    {3'b001, 7'b1111111, 3'b111, 4'd2, 1'b0},  // ANDI, funct7 ignored
    {3'b001, 7'b0000000, 3'b011, 4'd9, 1'b0},  // SLTIU
    {3'b010, 7'b0000000, 3'b101, 4'd0, 1'b0},  // load/store -> ADD
    {3'b011, 7'b0000000, 3'b000, 4'd1, 1'b0},  // branch -> SUB
    {3'b000, 7'b0000000, 3'b100, 4'd4, 1'b0},  // XOR
    {3'b101, 7'b0100000, 3'b111, 4'd0, 1'b0},  // class 1xx -> ADD
    {3'b001, 7'b1010101, 3'b110, 4'd3, 1'b0},  // ORI
    {3'b000, 7'b0000010, 3'b000, 4'd0, 1'b1},  // bad R funct7
    {3'b001, 7'b0000000, 3'b101, 4'd6, 1'b0},  // SRLI
    {3'b000, 7'b0100000, 3'b001, 4'd0, 1'b1},  // 0100000 with funct3=001
    {3'b000, 7'b0000000, 3'b100, 4'd4, 1'b0},  // XOR
    {3'b001, 7'b0100000, 3'b001, 4'd0, 1'b1},  // SLLI bad funct7
    {3'b001, 7'b0000000, 3'b001, 4'd5, 1'b0},  // SLLI
    {3'b001, 7'b0000001, 3'b101, 4'd0, 1'b1}   // SRxI bad funct7
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] aop,
                       input logic [6:0] f7, input logic [2:0] f3);
    valid_i  = v;
    ALU_Op_i = aop;
    funct7_i = f7;
    funct3_i = f3;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (obs !== 7'b0000_000) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs, 7'h00);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs !== 7'b0000_000) begin
      errors++; $display("FAIL post_reset_idle got %h exp %h", obs, 7'h00);
    end
    // Async reset while a result is being presented.
    drive(1'b1, 3'b000, 7'b0100000, 3'b000);
    step();
    checks++;
    if (obs !== {4'd1, 3'b100}) begin
      errors++; $display("FAIL reset_pre_out got %h exp %h", obs, {4'd1, 3'b100});
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0000_000) begin
      errors++; $display("FAIL reset_async got %h exp %h", obs, 7'h00);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 3'b000, 7'b0100000, 3'b000);
    step();
    checks++;
    if (obs !== {4'd1, 3'b100}) begin
      errors++; $display("FAIL single_sub got %h exp %h", obs, {4'd1, 3'b100});
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
    checks++;
    if ({valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL single_drop got v/b=%b exp 00", {valid_o, busy_o});
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 3'b001, 7'b0000000, 3'b000);  // ADDI
    step();
    checks++;
    if (obs !== {4'd0, 3'b100}) begin
      errors++; $display("FAIL stall_addi got %h exp %h", obs, {4'd0, 3'b100});
    end
    stall_i = 1'b1;
    drive(1'b1, 3'b001, 7'b0000000, 3'b100);  // XORI waiting upstream
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs !== {4'd0, 3'b100}) begin
        errors++; $display("FAIL stall_frozen[%0d] got %h exp %h", k, obs, {4'd0, 3'b100});
      end
    end
    stall_i = 1'b0;
    step();
    checks++;
    if (obs !== {4'd4, 3'b100}) begin
      errors++; $display("FAIL stall_release_xori got %h exp %h", obs, {4'd4, 3'b100});
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    logic [6:0]  exp_v;
    for (int i = 0; i < NV; i++) begin
      e = TBL[i];
      drive(1'b1, e[17:15], e[14:8], e[7:5]);
      step();
      exp_v = {e[4:1], 1'b1, 1'b0, e[0]};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL decode[%0d] got %h exp %h", i, obs, exp_v);
      end
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
    checks++;
    if ({valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_drain got v/b=%b exp 00", {valid_o, busy_o});
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b000, 7'b0000000, 3'b110);  // OR first so op is nonzero
    step();
    drive(1'b1, 3'b000, 7'b0000010, 3'b000);
    step();
    checks++;
    if (obs !== {4'd0, 3'b101}) begin
      errors++; $display("FAIL illegal_f7 got %h exp %h", obs, {4'd0, 3'b101});
    end
`ifndef ALU_CTRL_RV32M_EN
    drive(1'b1, 3'b000, 7'b0000000, 3'b111);  // AND
    step();
    drive(1'b1, 3'b000, 7'b0000001, 3'b100);  // DIV encoding without RV32M
    step();
    checks++;
    if (obs !== {4'd0, 3'b101}) begin
      errors++; $display("FAIL illegal_muldiv got %h exp %h", obs, {4'd0, 3'b101});
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL illegal_muldiv_busy got %b exp 0", busy_o);
    end
`endif
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, 3'b000, 7'b0000000, 3'b100);  // XOR
    step();
    drive(1'b1, 3'b000, 7'b0100000, 3'b000);  // SUB, to be discarded
    flush_i = 1'b1;
    step();
    checks++;
    if (obs !== 7'b0000_000) begin
      errors++; $display("FAIL flush_out got %h exp %h", obs, 7'h00);
    end
    flush_i = 1'b0;
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
  endtask

`ifdef ALU_CTRL_RV32M_EN
  task automatic test_div();
    int busy_cnt;
    busy_cnt = 0;
    drive(1'b1, 3'b000, 7'b0000001, 3'b100);  // DIV
    step();
    if (busy_o === 1'b1) busy_cnt++;
    checks++;
    if (obs !== {4'd12, 3'b010}) begin
      errors++; $display("FAIL div_accept got %h exp %h", obs, {4'd12, 3'b010});
    end
    drive(1'b1, 3'b000, 7'b0100000, 3'b000);  // SUB held upstream
    for (int k = 1; k < 7; k++) begin
      step();
      if (busy_o === 1'b1) busy_cnt++;
      checks++;
      if (obs !== {4'd12, 3'b010}) begin
        errors++; $display("FAIL div_busy[%0d] got %h exp %h", k, obs, {4'd12, 3'b010});
      end
    end
    step();
    checks++;
    if (obs !== {4'd12, 3'b100}) begin
      errors++; $display("FAIL div_done got %h exp %h", obs, {4'd12, 3'b100});
    end
    checks++;
    if (busy_cnt !== 7) begin
      errors++; $display("FAIL div_busy_cycles got %0d exp 7", busy_cnt);
    end
    step();
    checks++;
    if (obs !== {4'd1, 3'b100}) begin
      errors++; $display("FAIL div_next_sub got %h exp %h", obs, {4'd1, 3'b100});
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
  endtask

  task automatic test_mul_flush();
    drive(1'b1, 3'b000, 7'b0000001, 3'b000);  // MUL, full run
    step();
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    checks++;
    if (obs !== {4'd10, 3'b010}) begin
      errors++; $display("FAIL mul_accept got %h exp %h", obs, {4'd10, 3'b010});
    end
    step();
    checks++;
    if (obs !== {4'd10, 3'b010}) begin
      errors++; $display("FAIL mul_busy got %h exp %h", obs, {4'd10, 3'b010});
    end
    step();
    checks++;
    if (obs !== {4'd10, 3'b100}) begin
      errors++; $display("FAIL mul_done got %h exp %h", obs, {4'd10, 3'b100});
    end
    step();
    drive(1'b1, 3'b000, 7'b0000001, 3'b011);  // MULHU, flushed mid-run
    step();
    checks++;
    if (obs !== {4'd11, 3'b010}) begin
      errors++; $display("FAIL mulhu_accept got %h exp %h", obs, {4'd11, 3'b010});
    end
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
    flush_i = 1'b1;
    drive(1'b1, 3'b000, 7'b0100000, 3'b000);  // same-cycle valid_i, discarded
    step();
    flush_i = 1'b0;
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    checks++;
    if (obs !== 7'b0000_000) begin
      errors++; $display("FAIL mul_flush got %h exp %h", obs, 7'h00);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({valid_o, busy_o} !== 2'b00) begin
        errors++; $display("FAIL mul_flush_quiet[%0d] got v/b=%b exp 00", k, {valid_o, busy_o});
      end
    end
  endtask

  task automatic test_reset_busy();
    drive(1'b1, 3'b000, 7'b0000001, 3'b101);  // DIVU
    step();
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0000_000) begin
      errors++; $display("FAIL reset_mid_busy got %h exp %h", obs, 7'h00);
    end
    step();
    reset = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    stall_i = 1'b0;
    drive(1'b0, 3'b000, 7'b0000000, 3'b000);
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_flush();
`ifdef ALU_CTRL_RV32M_EN
    test_div();
    test_mul_flush();
    test_reset_busy();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, multi-cycle-aware successor to the combinational ALU control decoder in the RISC-V pipeline's EX stage.
- Decodes ALU_Op/funct3/full funct7 into an operation code, flags illegal encodings, and adds RV32M multiply/divide ops.
- Sequences multiply and divide ops for a configurable number of cycles, raising busy_o so the hazard unit stalls the front end.

Parameters:
- OP_W, 4, width of ALU_Operation_o; must be >= 4.
- MUL_LAT, 3, cycles from accept to valid_o for MUL/MULH/MULHSU/MULHU; must be >= 1.
- DIV_LAT, 8, cycles from accept to valid_o for DIV/DIVU/REM/REMU; must be >= 1.
- CNT_W (localparam), $clog2(max(MUL_LAT,DIV_LAT))+1, width of the latency counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous pipeline flush.
- stall_i  in  1  downstream hold.
- valid_i  in  1  an instruction is presented.
- funct7_i  in  7  instruction[31:25].
- funct3_i  in  3  instruction[14:12].
- ALU_Op_i  in  3  class from the main control unit.
- ALU_Operation_o  out  OP_W  registered op code.
- valid_o  out  1  ALU_Operation_o is valid for the ALU.
- busy_o  out  1  multi-cycle op in progress; no accept.
- illegal_o  out  1  qualified by valid_o; the encoding is undefined.

Behaviour:
- Reset (async, active-high): ALU_Operation_o=0 (ADD), valid_o=0, busy_o=0, illegal_o=0, cnt=0.
- Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10, MULH=11, MULHSU/MULHU both use the MULH code 11 with the signedness carried in the funct3 bits passed on by the datapath, DIV=12, DIVU=13, REM=14, REMU=15. Codes are zero-extended to OP_W.
- ALU_Op classes:
  - 000: R-type, decoded on funct3 plus funct7 in {0000000, 0100000, 0000001}.
  - 001: I-type arith. funct7 is ignored, except SLLI needs 0000000 and SRLI/SRAI need 0000000/0100000.
  - 010: ADD (load/store/jalr).
  - 011: SUB (branch compare).
  - 1xx: ADD.
- Illegal encodings give op=ADD and illegal_o=1; they are single-cycle. Illegal cases:
  - Any other funct7 in R-type.
  - 0100000 with funct3 not in {000, 101}.
  - Bad shift-immediate funct7.
- Accept condition: valid_i && !busy_o && !stall_i && !flush_i. Inputs are ignored otherwise; the upstream stage holds them.
- Single-cycle op accepted at edge N: ALU_Operation_o and valid_o=1 are visible after edge N (latency 1).
- Multi-cycle op, LAT = MUL_LAT or DIV_LAT:
  - At accept: ALU_Operation_o is loaded and held.
  - If LAT==1: behaves exactly like a single-cycle op.
  - Otherwise: busy_o=1, valid_o=0, cnt=LAT-1. cnt decrements each cycle while busy_o.
  - When busy_o && cnt==1: next edge gives busy_o=0, valid_o=1. valid_o therefore rises LAT edges after accept, and busy_o is high for exactly LAT-1 cycles.
  - The counter keeps running even when stall_i=1.
- States: IDLE (valid_o=0, busy_o=0), OUT (valid_o=1), BUSY (busy_o=1).
  - IDLE or OUT -> OUT or BUSY on accept.
  - OUT -> OUT held while stall_i=1 (outputs frozen).
  - OUT -> IDLE when !stall_i and no accept.
  - OUT -> OUT on back-to-back accept: a new op replaces the old one the same cycle stall_i is low.
  - BUSY -> OUT on count expiry.
- flush_i: synchronous. Priority over every event except reset. Next state is IDLE with all outputs at reset values, cnt=0. Applies mid-BUSY, and a same-cycle valid_i is discarded.
- Reset asserted mid-BUSY: immediate return to reset values.

Optional Feature:
- Macro: ALU_CTRL_RV32M_EN.
- Defined: RV32M decoding plus the counter and BUSY state as described above.
- Undefined: funct7=0000001 in R-type is illegal. No counter or BUSY state is built, busy_o is tied 0, and MUL_LAT/DIV_LAT are unused.

Decomposition:
- Package alu_ctrl_pkg holds:
  - Op-code localparams (ADD..REMU).
  - ALU_Op class constants (R_TYPE, I_TYPE, MEM, BRANCH).
  - funct7 constants (F7_BASE=0000000, F7_ALT=0100000, F7_MULDIV=0000001).
  - A function returning op latency class (single / mul / div).
- Sub-module alu_ctrl_decode: purely combinational mapping {funct7, ALU_Op, funct3} -> {op, illegal, lat_class}.
- alu_control_seq holds the FSM, counter and output registers.

Test Plan:
- Reset: reset=1 mid-BUSY -> immediately op=0, valid_o=0, busy_o=0, illegal_o=0.
- Single-cycle op: R-type funct7=0100000, funct3=000, valid_i=1 for one edge -> next cycle op=1 (SUB), valid_o=1, illegal_o=0; next cycle valid_o=0.
- DIV with DIV_LAT=8: ALU_Op=000, funct7=0000001, funct3=100 -> busy_o high for 7 cycles, valid_o=1 with op=12 on the 8th edge after accept; valid_i held meanwhile is not accepted until busy_o falls.
- Stall: stall_i=1 during valid_o=1 (ADDI, op=0) for 3 cycles -> outputs frozen 3 cycles, no accept; stall_i=0 plus next XORI -> op=4 the next cycle.
- Flush mid-MUL: flush_i on the 2nd cycle of MUL (MUL_LAT=3) -> busy_o=0, valid_o=0 next cycle, and no valid_o ever appears for that MUL.
- Illegal encoding: R-type funct7=0000010, funct3=000 -> valid_o=1, illegal_o=1, op=0. Build without ALU_CTRL_RV32M_EN: funct7=0000001 -> illegal_o=1, busy_o stays 0.
